// File: rtl/data_mover_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : data_mover_pkg                                            |
// | Purpose  : Shared state encoding and operation-mode constants for    |
// |            the BRAM-to-BRAM data mover.                              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package data_mover_pkg;

  // Job sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Operation applied to each word at the first pipeline stage.
  // Encoding 3 is reserved and behaves as a plain copy.
  localparam logic [1:0] MODE_COPY = 2'd0;
  localparam logic [1:0] MODE_ADD  = 2'd1;
  localparam logic [1:0] MODE_INV  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dm_core_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dm_core_pipe                                              |
// | Purpose  : CORE_DELAY-deep valid/data shift register; the selected   |
// |            operation is applied while loading stage 1.               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module dm_core_pipe
  import data_mover_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int CORE_DELAY = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [DWIDTH-1:0] i_data,
  input  logic [1:0]        i_mode,
  input  logic [DWIDTH-1:0] i_const,
  output logic              o_valid,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_busy
);

  logic [CORE_DELAY-1:0] valid_sr;
  logic [DWIDTH-1:0]     data_sr [CORE_DELAY];
  logic [DWIDTH-1:0]     op_data;

  // Stage-1 operation; the add wraps naturally at DWIDTH bits
  always_comb begin
    op_data = i_data;
    case (i_mode)
      MODE_ADD: op_data = i_data + i_const;
      MODE_INV: op_data = ~i_data;
      default:  op_data = i_data;
    endcase
  end

  // Shift valid flags and data one stage per clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_sr <= '0;
      for (int i = 0; i < CORE_DELAY; i++) begin
        data_sr[i] <= '0;
      end
    end else begin
      valid_sr[0] <= i_valid;
      data_sr[0]  <= op_data;
      for (int i = 1; i < CORE_DELAY; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        data_sr[i]  <= data_sr[i-1];
      end
    end
  end

  assign o_valid = valid_sr[CORE_DELAY-1];
  assign o_data  = data_sr[CORE_DELAY-1];
  assign o_busy  = |valid_sr;

endmodule
`default_nettype wire

// File: rtl/data_mover_bram_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : data_mover_bram_pipe                                      |
// | Purpose  : Moves N words BRAM0 -> processing pipe -> BRAM1 with      |
// |            programmable base addresses, mode and abort-with-drain.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module data_mover_bram_pipe
  import data_mover_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 12,
  parameter int MEM_SIZE   = 4096,
  parameter int CORE_DELAY = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_run,
  input  logic              i_abort,
  input  logic [AWIDTH:0]   i_num_cnt,
  input  logic [AWIDTH-1:0] i_src_addr,
  input  logic [AWIDTH-1:0] i_dst_addr,
  input  logic [1:0]        i_mode,
  input  logic [DWIDTH-1:0] i_const,
  output logic              o_idle,
  output logic              o_read,
  output logic              o_write,
  output logic              o_done,
  output logic              o_aborted,
  output logic [AWIDTH-1:0] addr_b0,
  output logic              ce_b0,
  output logic              we_b0,
  output logic [DWIDTH-1:0] d_b0,
  input  logic [DWIDTH-1:0] q_b0,
  output logic [AWIDTH-1:0] addr_b1,
  output logic              ce_b1,
  output logic              we_b1,
  output logic [DWIDTH-1:0] d_b1,
  input  logic [DWIDTH-1:0] q_b1
);

  localparam logic [AWIDTH:0] MAX_CNT = (AWIDTH+1)'(MEM_SIZE);

  state_t              state, next_state;
  logic [AWIDTH:0]     n_lat, rd_cnt, wr_cnt;
  logic [AWIDTH:0]     rd_next, wr_next, n_target, n_in;
  logic [AWIDTH-1:0]   src_lat, dst_lat;
  logic [1:0]          mode_lat;
  logic [DWIDTH-1:0]   const_lat;
  logic                aborted;
  logic                rd_valid;
  logic                issue;
  logic                pipe_valid, pipe_busy;
  logic [DWIDTH-1:0]   pipe_data;
  logic                unused_q_b1;

  // Port B of BRAM1 belongs to the host; its read data is never consumed
  assign unused_q_b1 = ^q_b1;

  // Requests beyond the memory depth are clamped to a full-depth move
  assign n_in = (i_num_cnt > MAX_CNT) ? MAX_CNT : i_num_cnt;

  // A read goes out every RUN cycle until the count is met or an abort landed
  assign issue   = (state == ST_RUN) && (rd_cnt < n_lat) && !aborted;
  assign rd_next = rd_cnt + (AWIDTH+1)'(issue);
  assign wr_next = wr_cnt + (AWIDTH+1)'(pipe_valid);

  // An abort arriving this cycle shrinks the target to the reads issued so far
  assign n_target = (i_abort && !aborted) ? rd_next : n_lat;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; once writes equal issued reads the pipe is necessarily empty
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (i_run) next_state = ST_RUN;
      ST_RUN:  if (wr_next == n_target) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Job parameters, counters, abort flag and the BRAM-latency valid stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_lat     <= '0;
      src_lat   <= '0;
      dst_lat   <= '0;
      mode_lat  <= MODE_COPY;
      const_lat <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      aborted   <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= issue;
      if (state == ST_IDLE && i_run) begin
        n_lat     <= n_in;
        src_lat   <= i_src_addr;
        dst_lat   <= i_dst_addr;
        mode_lat  <= i_mode;
        const_lat <= i_const;
        rd_cnt    <= '0;
        wr_cnt    <= '0;
        aborted   <= 1'b0;
      end else if (state == ST_RUN) begin
        rd_cnt <= rd_next;
        wr_cnt <= wr_next;
        if (i_abort && !aborted) begin
          aborted <= 1'b1;
          n_lat   <= rd_next;
        end
      end
    end
  end

  dm_core_pipe #(
    .DWIDTH     (DWIDTH),
    .CORE_DELAY (CORE_DELAY)
  ) u_core_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_valid (rd_valid),
    .i_data  (q_b0),
    .i_mode  (mode_lat),
    .i_const (const_lat),
    .o_valid (pipe_valid),
    .o_data  (pipe_data),
    .o_busy  (pipe_busy)
  );

  // BRAM0 read port: address is driven only while a read is issued
  assign ce_b0   = issue;
  assign we_b0   = 1'b0;
  assign d_b0    = '0;
  assign addr_b0 = issue ? (src_lat + rd_cnt[AWIDTH-1:0]) : '0;

  // BRAM1 write port: last pipeline stage drives a write directly
  assign ce_b1   = pipe_valid;
  assign we_b1   = pipe_valid;
  assign addr_b1 = pipe_valid ? (dst_lat + wr_cnt[AWIDTH-1:0]) : '0;
  assign d_b1    = pipe_valid ? pipe_data : '0;

  // Status
  assign o_idle    = (state == ST_IDLE);
  assign o_read    = issue;
  assign o_write   = rd_valid | pipe_busy;
  assign o_done    = (state == ST_DONE);
  assign o_aborted = aborted;

endmodule
`default_nettype wire

// File: tb/tb_data_mover_bram_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_data_mover_bram_pipe                                   |
// | Purpose  : Self-checking bench with BRAM models and a word-level     |
// |            reference of each job's effect on BRAM1.                  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_data_mover_bram_pipe;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int MS = 4096;
  localparam int CD = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_run, i_abort;
  logic [AW:0]   i_num_cnt;
  logic [AW-1:0] i_src_addr, i_dst_addr;
  logic [1:0]    i_mode;
  logic [DW-1:0] i_const;
  logic          o_idle, o_read, o_write, o_done, o_aborted;
  logic [AW-1:0] addr_b0, addr_b1;
  logic          ce_b0, we_b0, ce_b1, we_b1;
  logic [DW-1:0] d_b0, d_b1;
  logic [DW-1:0] q_b0 = '0;
  logic [DW-1:0] q_b1 = '0;

  logic [DW-1:0] mem0 [MS];
  logic [DW-1:0] mem1 [MS];
  logic [DW-1:0] exp1 [MS];

  int n_cmp = 0;
  int n_bad = 0;

  data_mover_bram_pipe #(
    .DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS), .CORE_DELAY(CD)
  ) dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_abort(i_abort),
    .i_num_cnt(i_num_cnt), .i_src_addr(i_src_addr), .i_dst_addr(i_dst_addr),
    .i_mode(i_mode), .i_const(i_const),
    .o_idle(o_idle), .o_read(o_read), .o_write(o_write), .o_done(o_done),
    .o_aborted(o_aborted),
    .addr_b0(addr_b0), .ce_b0(ce_b0), .we_b0(we_b0), .d_b0(d_b0), .q_b0(q_b0),
    .addr_b1(addr_b1), .ce_b1(ce_b1), .we_b1(we_b1), .d_b1(d_b1), .q_b1(q_b1)
  );

  always #5 clk = ~clk;

  // Port-A behaviour of the two BRAMs: registered read on BRAM0, write on BRAM1
  always @(posedge clk) begin
    if (ce_b0 && !we_b0) q_b0 <= mem0[addr_b0];
    if (ce_b1 && we_b1)  mem1[addr_b1] <= d_b1;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_op(input int mode, input logic [DW-1:0] c,
                                           input logic [DW-1:0] x);
    if (mode == 1)      return x + c;
    else if (mode == 2) return ~x;
    else                return x;
  endfunction

  task automatic scramble_inputs();
    i_num_cnt  = (AW+1)'($urandom_range(0, MS));
    i_src_addr = AW'($urandom);
    i_dst_addr = AW'($urandom);
    i_mode     = 2'($urandom);
    i_const    = $urandom;
  endtask

  // One job: drive it, watch every cycle, then compare against the reference.
  // abort_at / reset_at < 0 disable those events.
  task automatic run_job(input int n, input int src, input int dst, input int mode,
                         input logic [DW-1:0] cnst, input int abort_at,
                         input int reset_at, input bit stray_run,
                         input bit abort_with_run);
    int reads = 0, writes = 0, c = 0, done_c = -1, first_w = -1;
    int bad_rd = 0, bad_wr = 0, mism = 0, m;
    bit was_reset = 0;
    bit exp_abort;
    for (int i = 0; i < MS; i++) exp1[i] = mem1[i];
    exp_abort = (abort_at >= 0) && (abort_at < n);
    m = exp_abort ? abort_at + 1 : n;

    @(negedge clk);
    i_num_cnt  = (AW+1)'(n);
    i_src_addr = AW'(src);
    i_dst_addr = AW'(dst);
    i_mode     = 2'(mode);
    i_const    = cnst;
    i_run      = 1'b1;
    i_abort    = abort_with_run;
    @(negedge clk);
    i_run   = 1'b0;
    i_abort = 1'b0;
    scramble_inputs();

    while (c < n + CD + 40) begin
      i_abort = 1'b0;
      if (we_b0 || d_b0 != '0) bad_rd++;
      if (ce_b0) begin
        if (int'(addr_b0) != (src + reads) % MS) bad_rd++;
        if (reads == abort_at) i_abort = 1'b1;
        reads++;
      end
      if (ce_b1 && we_b1) begin
        if (first_w < 0) first_w = c;
        if (int'(addr_b1) != (dst + writes) % MS) bad_wr++;
        writes++;
      end
      if (o_done) begin
        done_c = c;
        break;
      end
      if (reset_at >= 0 && reads == reset_at) begin
        reset = 1'b1;
        #1;
        check("reset_status", {o_idle, o_read, o_write, o_done, o_aborted,
                               ce_b0, we_b0, ce_b1, we_b1}, 9'b1_0000_0000);
        check("reset_addr", {addr_b0, addr_b1}, 0);
        check("reset_data", {d_b0, d_b1}, 0);
        @(posedge clk);
        #1;
        check("reset_hold_idle", {o_idle, ce_b0, ce_b1}, 3'b100);
        @(negedge clk);
        reset = 1'b0;
        was_reset = 1;
        break;
      end
      i_run = (stray_run && c == 3);
      @(negedge clk);
      c++;
    end
    i_run   = 1'b0;
    i_abort = 1'b0;
    if (was_reset) return;

    check("done_cycle", done_c, (n == 0) ? 1 : m + CD + 1);
    check("read_count", reads, m);
    check("write_count", writes, m);
    check("first_write_cycle", first_w, (m > 0) ? CD + 1 : -1);
    check("rd_port_errors", bad_rd, 0);
    check("wr_addr_errors", bad_wr, 0);
    check("aborted_flag", o_aborted, exp_abort);
    @(negedge clk);
    check("idle_after_done", {o_idle, o_done}, 2'b10);
    if (stray_run) begin
      @(negedge clk);
      check("stray_run_ignored", {o_idle, o_read}, 2'b10);
    end

    for (int k = 0; k < m; k++)
      exp1[(dst + k) % MS] = ref_op(mode, cnst, mem0[(src + k) % MS]);
    for (int i = 0; i < MS; i++)
      if (mem1[i] !== exp1[i]) mism++;
    check("bram1_words_wrong", mism, 0);
  endtask

  initial begin
    reset      = 1'b1;
    i_run      = 1'b0;
    i_abort    = 1'b0;
    i_num_cnt  = '0;
    i_src_addr = '0;
    i_dst_addr = '0;
    i_mode     = '0;
    i_const    = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {o_idle, o_read, o_write, o_done, o_aborted,
                          ce_b0, we_b0, ce_b1, we_b1}, 9'b1_0000_0000);
    reset = 1'b0;

    // Plain copy of an index ramp
    for (int i = 0; i < MS; i++) mem0[i] = (i < 3840) ? DW'(i) : $urandom;
    run_job(3840, 0, 0, 0, '0, -1, -1, 0, 0);

    // Add with wrapping source address and wrapping data
    for (int i = 0; i < MS; i++) mem0[i] = $urandom;
    run_job(512, 'hF00, 'h080, 1, 32'hFFFF_FFFF, -1, -1, 0, 0);

    // Full-depth invert
    run_job(MS, 0, 0, 2, '0, -1, -1, 0, 0);

    // Empty job
    run_job(0, $urandom_range(0, MS-1), $urandom_range(0, MS-1), 0, '0, -1, -1, 0, 0);

    // Abort with drain
    run_job(1000, $urandom_range(0, MS-1), $urandom_range(0, MS-1),
            $urandom_range(0, 3), $urandom, 100, -1, 0, 0);

    // Reset mid-job, then a short job with a stray start pulse
    run_job(1000, 0, 0, 0, '0, -1, 200, 0, 0);
    run_job(16, $urandom_range(0, MS-1), $urandom_range(0, MS-1),
            1, $urandom, -1, -1, 1, 0);

    // Random short jobs; the first also raises abort together with run
    for (int j = 0; j < 4; j++) begin
      run_job($urandom_range(1, 64), $urandom_range(0, MS-1), $urandom_range(0, MS-1),
              $urandom_range(0, 3), $urandom, -1, -1, 0, (j == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
